// File: rtl/frac_baud_generator.sv
// Fractional-N baud clock-enable generator with oversampling index,
// mid-bit/bit strobes, enable gating, phase resync and glitch-free divisor reload.
module frac_baud_generator #(
  parameter int DVSR_WIDTH = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int OVS_RATE   = 16,
  parameter int RST_DVSR   = 324,
  parameter int RST_FRAC   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic                        resync_i,
  input  logic                        divisor_load_i,
  input  logic [DVSR_WIDTH-1:0]       divisor_int_i,
  input  logic [FRAC_WIDTH-1:0]       divisor_frac_i,
  output logic                        ov_tick_o,
  output logic                        baud_tick_o,
  output logic                        mid_bit_tick_o,
  output logic [$clog2(OVS_RATE)-1:0] ovs_index_o
);

  localparam int IDX_W = $clog2(OVS_RATE);
  // One extra counter bit so a limit of D_max + carry is still reachable.
  localparam int CNT_W = DVSR_WIDTH + 1;

  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic                  ov_tick_q, ov_tick_d;
  logic                  baud_tick_q, baud_tick_d;
  logic                  mid_tick_q, mid_tick_d;
  logic                  pending_q, pending_d;
  logic [DVSR_WIDTH-1:0] pend_int_q, pend_int_d;
  logic [FRAC_WIDTH-1:0] pend_frac_q, pend_frac_d;
  logic [DVSR_WIDTH-1:0] act_int_q, act_int_d;
  logic [FRAC_WIDTH-1:0] act_frac_q, act_frac_d;

  logic [CNT_W-1:0]      limit;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic [IDX_W-1:0]      index_next;
  logic                  wrap;
  logic                  apply;

  assign limit      = {1'b0, act_int_q} + CNT_W'(carry_q);
  assign frac_sum   = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign index_next = (index_q == IDX_W'(OVS_RATE - 1)) ? '0 : index_q + IDX_W'(1);
  assign wrap       = enable_i && !resync_i && (counter_q == limit);
  assign apply      = resync_i || !enable_i || wrap;

  // Period counter, fractional accumulator, oversample index and strobe generation.
  always_comb begin
    counter_d   = counter_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    index_d     = index_q;
    ov_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    mid_tick_d  = 1'b0;
    if (resync_i) begin
      counter_d = '0;
      acc_d     = '0;
      carry_d   = 1'b0;
      index_d   = '0;
    end else if (enable_i) begin
      if (wrap) begin
        counter_d          = '0;
        {carry_d, acc_d}   = frac_sum;
        index_d            = index_next;
        ov_tick_d          = 1'b1;
        baud_tick_d        = (index_next == '0);
        mid_tick_d         = (index_next == IDX_W'(OVS_RATE / 2));
      end else begin
        counter_d = counter_q + CNT_W'(1);
      end
    end
  end

  // Divisor reload: capture into pending, promote to active only on an apply edge.
  always_comb begin
    pending_d   = pending_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    if (apply) begin
      if (divisor_load_i) begin
        act_int_d  = divisor_int_i;
        act_frac_d = divisor_frac_i;
      end else if (pending_q) begin
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
      end
      pending_d = 1'b0;
    end else if (divisor_load_i) begin
      pending_d   = 1'b1;
      pend_int_d  = divisor_int_i;
      pend_frac_d = divisor_frac_i;
    end
  end

  // State registers; reset clears strobes asynchronously and reloads the reset divisor.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      counter_q   <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      index_q     <= '0;
      ov_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      mid_tick_q  <= 1'b0;
      pending_q   <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      act_int_q   <= DVSR_WIDTH'(RST_DVSR);
      act_frac_q  <= FRAC_WIDTH'(RST_FRAC);
    end else begin
      counter_q   <= counter_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      index_q     <= index_d;
      ov_tick_q   <= ov_tick_d;
      baud_tick_q <= baud_tick_d;
      mid_tick_q  <= mid_tick_d;
      pending_q   <= pending_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
    end
  end

  assign ov_tick_o      = ov_tick_q;
  assign baud_tick_o    = baud_tick_q;
  assign mid_bit_tick_o = mid_tick_q;
  assign ovs_index_o    = index_q;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Scoreboard bench for frac_baud_generator: a behavioural model predicts every
// tick event and the oversample index; a negedge monitor compares against the DUT.
module tb_frac_baud_generator;

  localparam int DVSR_WIDTH = 16;
  localparam int FRAC_WIDTH = 4;
  localparam int OVS_RATE   = 16;
  localparam int RST_DVSR   = 324;
  localparam int RST_FRAC   = 8;
  localparam int CNT_MOD    = 1 << (DVSR_WIDTH + 1);
  localparam int FRAC_MOD   = 1 << FRAC_WIDTH;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        enable = 1'b0;
  logic                        resync = 1'b0;
  logic                        load = 1'b0;
  logic [DVSR_WIDTH-1:0]       div_int = '0;
  logic [FRAC_WIDTH-1:0]       div_frac = '0;
  logic                        ov_tick;
  logic                        baud_tick;
  logic                        mid_tick;
  logic [$clog2(OVS_RATE)-1:0] ovs_index;

  frac_baud_generator #(
    .DVSR_WIDTH(DVSR_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .OVS_RATE  (OVS_RATE),
    .RST_DVSR  (RST_DVSR),
    .RST_FRAC  (RST_FRAC)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .enable_i      (enable),
    .resync_i      (resync),
    .divisor_load_i(load),
    .divisor_int_i (div_int),
    .divisor_frac_i(div_frac),
    .ov_tick_o     (ov_tick),
    .baud_tick_o   (baud_tick),
    .mid_bit_tick_o(mid_tick),
    .ovs_index_o   (ovs_index)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    bit baud;
    bit mid;
  } ev_t;

  ev_t ev_q[$];
  int  idx_q[$];
  int  edge_cnt = 0;
  int  total_cnt = 0;
  int  pass_cnt = 0;

  // Reference model state: position inside the current period, fractional phase,
  // whether the current period is stretched, and number of ticks since restart.
  int  m_act_d, m_act_f, m_pend, m_pend_d, m_pend_f;
  int  m_elapsed, m_phase, m_ext, m_ticks;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
  endfunction

  function automatic void modelReset();
    m_act_d   = RST_DVSR;
    m_act_f   = RST_FRAC;
    m_pend    = 0;
    m_pend_d  = 0;
    m_pend_f  = 0;
    m_elapsed = 0;
    m_phase   = 0;
    m_ext     = 0;
    m_ticks   = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void modelEdge();
    bit apply = 0;
    bit tick = 0;
    int sum;
    int idx;
    if (!rst_n) begin
      modelReset();
      idx_q.push_back(0);
      return;
    end
    if (resync) begin
      m_elapsed = 0;
      m_phase   = 0;
      m_ext     = 0;
      m_ticks   = 0;
      apply     = 1;
    end else if (!enable) begin
      apply = 1;
    end else if (m_elapsed == m_act_d + m_ext) begin
      tick      = 1;
      m_elapsed = 0;
      sum       = m_phase + m_act_f;
      m_ext     = sum / FRAC_MOD;
      m_phase   = sum % FRAC_MOD;
      m_ticks   = (m_ticks + 1) % OVS_RATE;
      apply     = 1;
    end else begin
      m_elapsed = (m_elapsed + 1) % CNT_MOD;
    end
    if (apply) begin
      if (load) begin
        m_act_d = int'(div_int);
        m_act_f = int'(div_frac);
      end else if (m_pend != 0) begin
        m_act_d = m_pend_d;
        m_act_f = m_pend_f;
      end
      m_pend = 0;
    end else if (load) begin
      m_pend   = 1;
      m_pend_d = int'(div_int);
      m_pend_f = int'(div_frac);
    end
    idx = m_ticks;
    idx_q.push_back(idx);
    if (tick) ev_q.push_back('{stamp: edge_cnt, baud: (idx == 0), mid: (idx == OVS_RATE / 2)});
  endfunction

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_cnt++;
      modelEdge();
      #1;
    end
  endtask

  task automatic loadDivisor(input int d, input int f);
    div_int  = DVSR_WIDTH'(d);
    div_frac = FRAC_WIDTH'(f);
    load     = 1'b1;
    applyStimulus(1);
    load     = 1'b0;
  endtask

  // Monitor: per-cycle index check and tick-event scoreboard, sampled on negedge.
  ev_t mon_ev;
  int  mon_idx;
  always @(negedge clk) begin
    if (idx_q.size() > 0) begin
      mon_idx = idx_q.pop_front();
      checkOutput("ovs_index", int'(ovs_index), mon_idx);
    end
    while (ev_q.size() > 0 && ev_q[0].stamp < edge_cnt) begin
      total_cnt++;
      $display("[TB] FAIL missing_tick: expected after edge %0d, not observed by edge %0d", ev_q[0].stamp, edge_cnt);
      void'(ev_q.pop_front());
    end
    if (ov_tick || baud_tick || mid_tick) begin
      if (ev_q.size() > 0 && ev_q[0].stamp == edge_cnt) begin
        mon_ev = ev_q.pop_front();
        checkOutput("strobes{ov,baud,mid}", int'({ov_tick, baud_tick, mid_tick}),
                    int'({1'b1, mon_ev.baud, mon_ev.mid}));
      end else begin
        total_cnt++;
        $display("[TB] FAIL spurious_tick: strobes {ov,baud,mid}=%b after edge %0d, none expected",
                 {ov_tick, baud_tick, mid_tick}, edge_cnt);
      end
    end
  end

  // Wait until the model reaches a condition, bounded; an expired bound is a failure.
  task automatic waitElapsed(input int target, input int budget);
    int n = 0;
    while (m_elapsed != target && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("wait_elapsed_reached", m_elapsed, target);
  endtask

  initial begin
    int r;
    int n;
    modelReset();

    // Reset held for a few edges, then released while disabled.
    applyStimulus(3);
    rst_n = 1'b1;

    // Plan 1: D=3, F=0 applied immediately via a disabled edge.
    loadDivisor(3, 0);
    enable = 1'b1;
    applyStimulus(140);

    // Plan 2: D=3, F=8 loaded together with a resync.
    resync = 1'b1;
    loadDivisor(3, 8);
    resync = 1'b0;
    applyStimulus(90);

    // Plan 3: running D=9, reload D=3 mid-period.
    resync = 1'b1;
    loadDivisor(9, 0);
    resync = 1'b0;
    applyStimulus(25);
    waitElapsed(5, 20);
    loadDivisor(3, 0);
    applyStimulus(30);

    // Plan 4: resync at index 7, counter 2.
    n = 0;
    while (!(m_ticks == 7 && m_elapsed == 2) && n < 200) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("resync_point_reached", m_ticks * 100 + m_elapsed, 702);
    resync = 1'b1;
    applyStimulus(1);
    resync = 1'b0;
    applyStimulus(40);

    // Plan 5: disable for 10 edges at counter 2, with a load while disabled.
    waitElapsed(2, 10);
    enable = 1'b0;
    applyStimulus(3);
    loadDivisor(3, 4);
    applyStimulus(6);
    enable = 1'b1;
    applyStimulus(30);

    // Boundary: D=0, F=0 ticks every cycle.
    enable = 1'b0;
    loadDivisor(0, 0);
    enable = 1'b1;
    applyStimulus(20);

    // Randomized traffic: loads, resyncs and short disable bursts.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        loadDivisor(int'($urandom_range(0, 7)), int'($urandom_range(0, FRAC_MOD - 1)));
      end else if (r < 7) begin
        resync = 1'b1;
        if (r == 6) loadDivisor(int'($urandom_range(0, 7)), int'($urandom_range(0, FRAC_MOD - 1)));
        else applyStimulus(1);
        resync = 1'b0;
      end else if (r < 9 && m_pend == 0) begin
        enable = 1'b0;
        applyStimulus(int'($urandom_range(1, 5)));
        enable = 1'b1;
      end else begin
        applyStimulus(1);
      end
    end

    // Plan 6: asynchronous reset mid-period, then reset divisor timing.
    resync = 1'b1;
    loadDivisor(5, 0);
    resync = 1'b0;
    waitElapsed(3, 10);
    #1;
    rst_n = 1'b0;
    modelReset();
    ev_q.delete();
    idx_q.delete();
    idx_q.push_back(0);
    #1;
    checkOutput("async_reset_ov", int'(ov_tick), 0);
    checkOutput("async_reset_baud", int'(baud_tick), 0);
    checkOutput("async_reset_mid", int'(mid_tick), 0);
    checkOutput("async_reset_index", int'(ovs_index), 0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(340);

    @(negedge clk);
    #1;
    while (ev_q.size() > 0) begin
      total_cnt++;
      $display("[TB] FAIL missing_tick: expected after edge %0d, never seen", ev_q[0].stamp);
      void'(ev_q.pop_front());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
